io_led_pwm: RTL and testbench



---
 rtl/io_led_pwm_pkg.sv | 21 ++
 rtl/io_led_pwm_ch.sv | 61 ++++++
 rtl/io_led_pwm.sv | 141 ++++++++++++++
 tb/tb_io_led_pwm.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_led_pwm_pkg.sv
// Register map and bit positions shared by the LED/PWM peripheral and its channels.
package io_led_pwm_pkg;

    localparam logic [13:0] OFF_CTRL     = 14'd0;
    localparam logic [13:0] OFF_PRESCALE = 14'd1;
    localparam logic [13:0] OFF_BLINK    = 14'd2;
    localparam logic [13:0] OFF_STATUS   = 14'd3;
    localparam logic [13:0] OFF_DUTY0    = 14'd4;

    localparam int EN_BIT       = 0;
    localparam int PHASE_BIT    = 16;
    localparam int BLINK_EN_BIT = 16;
    localparam int INV_BIT      = 17;

    // Per-channel configuration fields carried by a DUTY[i] write.
    typedef struct packed {
        logic inv;
        logic blink_en;
    } ch_mode_t;

endpackage

// File: rtl/io_led_pwm_ch.sv
// One LED channel: shadowed duty, PWM compare, blink gating, polarity and output flop.
module io_led_pwm_ch
    import io_led_pwm_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr,
    input  logic [PW-1:0] i_duty,
    input  ch_mode_t      i_mode,
    input  logic          i_en,
    input  logic          i_period_end,
    input  logic [PW-1:0] i_pwm_cnt,
    input  logic          i_phase,
    output logic [31:0]   o_rdata,
    output logic          o_led
);

    logic [PW-1:0] r_duty_shd;
    logic [PW-1:0] r_duty_act;
    ch_mode_t      r_mode;
    logic          r_led;
    logic          w_raw;
    logic          w_gated;

    // The active duty only moves at a period boundary (or while stopped) so a
    // running waveform never sees a half-old, half-new compare value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_shd <= '0;
            r_duty_act <= '0;
            r_mode     <= '0;
        end else begin
            if (i_wr) begin
                r_duty_shd <= i_duty;
                r_mode     <= i_mode;
            end
            if (!i_en || i_period_end)
                r_duty_act <= i_wr ? i_duty : r_duty_shd;
        end
    end

    assign w_raw   = (r_duty_act == '1) || (i_pwm_cnt < r_duty_act);
    assign w_gated = w_raw && !(r_mode.blink_en && i_phase);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_led <= 1'b0;
        else        r_led <= i_en ? (w_gated ^ r_mode.inv) : r_mode.inv;
    end

    always_comb begin
        o_rdata               = '0;
        o_rdata[PW-1:0]       = r_duty_shd;
        o_rdata[BLINK_EN_BIT] = r_mode.blink_en;
        o_rdata[INV_BIT]      = r_mode.inv;
    end

    assign o_led = r_led;

endmodule

// File: rtl/io_led_pwm.sv
// Multi-channel LED/GPIO PWM peripheral on the dma_io bus with shared prescaler and blink.
module io_led_pwm
    import io_led_pwm_pkg::*;
#(
    parameter int          NCH      = 3,
    parameter int          PW       = 8,
    parameter logic [13:0] BASE_ADR = 14'h3C00
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           dma_io_we,
    input  logic [13:0]    dma_io_wadr,
    input  logic [31:0]    dma_io_wdata,
    input  logic [13:0]    dma_io_radr,
    input  logic [31:0]    dma_io_rdata_in,
    output logic [31:0]    dma_io_rdata,
    output logic [NCH-1:0] led_out
);

    localparam logic [13:0] NREG = OFF_DUTY0 + 14'(NCH);

    logic [13:0] w_wofs, w_rofs;
    logic        w_wr_hit, w_rd_hit;
    logic        w_wr_ctrl, w_wr_pre, w_wr_blk;
    logic        w_tick, w_period_end;
    logic [31:0] w_rd_data;
    logic        w_unused;

    logic [NCH-1:0]       w_duty_wr;
    logic [NCH-1:0][31:0] w_ch_rd;

    logic          r_en;
    logic [15:0]   r_prescale, r_blink;
    logic [15:0]   r_pre_cnt, r_blink_cnt;
    logic [PW-1:0] r_pwm_cnt;
    logic          r_phase;
    logic          r_hit;
    logic [31:0]   r_rdata;

    assign w_unused = ^dma_io_wdata;

    // The >= guard keeps addresses below the window from wrapping into it.
    assign w_wofs    = dma_io_wadr - BASE_ADR;
    assign w_rofs    = dma_io_radr - BASE_ADR;
    assign w_wr_hit  = dma_io_we && (dma_io_wadr >= BASE_ADR) && (w_wofs < NREG);
    assign w_rd_hit  = (dma_io_radr >= BASE_ADR) && (w_rofs < NREG);
    assign w_wr_ctrl = w_wr_hit && (w_wofs == OFF_CTRL);
    assign w_wr_pre  = w_wr_hit && (w_wofs == OFF_PRESCALE);
    assign w_wr_blk  = w_wr_hit && (w_wofs == OFF_BLINK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en       <= 1'b0;
            r_prescale <= '0;
            r_blink    <= '0;
        end else begin
            if (w_wr_ctrl) r_en       <= dma_io_wdata[EN_BIT];
            if (w_wr_pre)  r_prescale <= dma_io_wdata[15:0];
            if (w_wr_blk)  r_blink    <= dma_io_wdata[15:0];
        end
    end

    assign w_tick       = r_en && (r_pre_cnt == r_prescale);
    assign w_period_end = w_tick && (r_pwm_cnt == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt   <= '0;
            r_pwm_cnt   <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (!r_en) begin
            r_pre_cnt   <= '0;
            r_pwm_cnt   <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else begin
            r_pre_cnt <= (w_wr_pre || w_tick) ? 16'd0 : r_pre_cnt + 16'd1;
            if (w_tick) r_pwm_cnt <= r_pwm_cnt + PW'(1);
            // A BLINK write restarts the half-period count but keeps the current phase.
            if (w_wr_blk) begin
                r_blink_cnt <= '0;
            end else if (w_period_end) begin
                if (r_blink_cnt == r_blink) begin
                    r_blink_cnt <= '0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 16'd1;
                end
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign w_duty_wr[i] = w_wr_hit && (w_wofs == OFF_DUTY0 + 14'(i));

        io_led_pwm_ch #(.PW(PW)) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_wr         (w_duty_wr[i]),
            .i_duty       (dma_io_wdata[PW-1:0]),
            .i_mode       ({dma_io_wdata[INV_BIT], dma_io_wdata[BLINK_EN_BIT]}),
            .i_en         (r_en),
            .i_period_end (w_period_end),
            .i_pwm_cnt    (r_pwm_cnt),
            .i_phase      (r_phase),
            .o_rdata      (w_ch_rd[i]),
            .o_led        (led_out[i])
        );
    end

    always_comb begin
        w_rd_data = '0;
        case (w_rofs)
            OFF_CTRL:     w_rd_data[EN_BIT] = r_en;
            OFF_PRESCALE: w_rd_data[15:0]   = r_prescale;
            OFF_BLINK:    w_rd_data[15:0]   = r_blink;
            OFF_STATUS: begin
                w_rd_data[15:0]      = 16'(r_pwm_cnt);
                w_rd_data[PHASE_BIT] = r_phase;
            end
            default: begin
                for (int i = 0; i < NCH; i++)
                    if (w_rofs == OFF_DUTY0 + 14'(i)) w_rd_data = w_ch_rd[i];
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_hit   <= w_rd_hit;
            r_rdata <= w_rd_hit ? w_rd_data : 32'd0;
        end
    end

    assign dma_io_rdata = r_hit ? r_rdata : dma_io_rdata_in;

endmodule

// File: tb/tb_io_led_pwm.sv
// Randomized scoreboard bench for io_led_pwm against a time/count-based reference model.
module tb_io_led_pwm;

    localparam int          NCH    = 3;
    localparam int          PW     = 8;
    localparam logic [13:0] BASE   = 14'h3C00;
    localparam int          PERIOD = 1 << PW;
    localparam logic [31:0] RD_IN  = 32'hDEADBEEF;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           dma_io_we = 1'b0;
    logic [13:0]    dma_io_wadr = '0;
    logic [31:0]    dma_io_wdata = '0;
    logic [13:0]    dma_io_radr = '0;
    logic [31:0]    dma_io_rdata_in = RD_IN;
    logic [31:0]    dma_io_rdata;
    logic [NCH-1:0] led_out;

    io_led_pwm #(.NCH(NCH), .PW(PW), .BASE_ADR(BASE)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dma_io_we       (dma_io_we),
        .dma_io_wadr     (dma_io_wadr),
        .dma_io_wdata    (dma_io_wdata),
        .dma_io_radr     (dma_io_radr),
        .dma_io_rdata_in (dma_io_rdata_in),
        .dma_io_rdata    (dma_io_rdata),
        .led_out         (led_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int             due;
        logic [NCH-1:0] led;
        logic [31:0]    rd;
    } exp_t;
    exp_t q[$];

    // Reference model: counts of cycles, ticks and period ends since the last restart.
    bit m_en;
    int m_prescale, m_blink, m_pre, m_ticks, m_pe, m_pbase;
    int m_shd[NCH], m_act[NCH];
    bit m_blen[NCH], m_inv[NCH];

    function automatic void model_reset();
        m_en = 0; m_prescale = 0; m_blink = 0; m_pre = 0; m_ticks = 0; m_pe = 0; m_pbase = 0;
        for (int i = 0; i < NCH; i++) begin
            m_shd[i] = 0; m_act[i] = 0; m_blen[i] = 0; m_inv[i] = 0;
        end
    endfunction

    function automatic bit m_phase();
        return 1'(m_pbase ^ ((m_pe / (m_blink + 1)) % 2));
    endfunction

    function automatic void model_step(bit we, logic [13:0] wadr, logic [31:0] wd, logic [13:0] radr);
        int   woff = int'(wadr) - int'(BASE);
        int   roff = int'(radr) - int'(BASE);
        bit   wv   = we && woff >= 0 && woff < 4 + NCH;
        int   pwm  = m_ticks % PERIOD;
        bit   ph   = m_phase();
        bit   tick, pend, en_old, raw;
        exp_t e;
        e.due = cyc + 1;
        for (int i = 0; i < NCH; i++) begin
            raw = (m_act[i] == PERIOD - 1) || (pwm < m_act[i]);
            e.led[i] = m_en ? ((raw && !(m_blen[i] && ph)) ^ m_inv[i]) : m_inv[i];
        end
        e.rd = RD_IN;
        if (roff >= 0 && roff < 4 + NCH) begin
            e.rd = 32'd0;
            case (roff)
                0: e.rd[0] = m_en;
                1: e.rd = 32'(m_prescale);
                2: e.rd = 32'(m_blink);
                3: e.rd = (32'(ph) << 16) | 32'(pwm);
                default: e.rd = (32'(m_inv[roff-4]) << 17) | (32'(m_blen[roff-4]) << 16) | 32'(m_shd[roff-4]);
            endcase
        end
        q.push_back(e);
        tick = m_en && (m_pre == m_prescale);
        pend = tick && (pwm == PERIOD - 1);
        en_old = m_en;
        if (!m_en) begin
            m_pre = 0; m_ticks = 0; m_pe = 0; m_pbase = 0;
        end else begin
            m_pre = (wv && woff == 1) || tick ? 0 : m_pre + 1;
            if (tick) m_ticks++;
            if (wv && woff == 2) begin m_pbase = int'(ph); m_pe = 0; end
            else if (pend) m_pe++;
        end
        if (wv) begin
            case (woff)
                0: m_en = wd[0];
                1: m_prescale = int'(wd[15:0]);
                2: m_blink = int'(wd[15:0]);
                3: ;
                default: begin
                    m_shd[woff-4]  = int'(wd[PW-1:0]);
                    m_blen[woff-4] = wd[16];
                    m_inv[woff-4]  = wd[17];
                end
            endcase
        end
        for (int i = 0; i < NCH; i++)
            if (!en_old || pend) m_act[i] = m_shd[i];
    endfunction

    // Monitor: compares the DUT against whatever expectation falls due this cycle.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            total++;
            if (led_out !== e.led) begin
                bad++;
                $display("FAIL led cyc=%0d got=%b exp=%b", cyc, led_out, e.led);
            end
            total++;
            if (dma_io_rdata !== e.rd) begin
                bad++;
                $display("FAIL rdata cyc=%0d radr_prev got=%h exp=%h", cyc, dma_io_rdata, e.rd);
            end
        end
    end

    bit cnt_on = 0;
    int hi_cnt = 0;

    function automatic logic [13:0] A(input int off);
        return BASE + 14'(off);
    endfunction

    function automatic logic [13:0] rand_radr();
        return ($urandom_range(0, 9) == 0) ? 14'h0123 : A(int'($urandom_range(0, 8)));
    endfunction

    task automatic step(input bit we, input logic [13:0] wadr, input logic [31:0] wd, input logic [13:0] radr);
        @(posedge clk);
        #1;
        if (cnt_on) hi_cnt += int'(led_out[0]);
        dma_io_we = we; dma_io_wadr = wadr; dma_io_wdata = wd; dma_io_radr = radr;
        model_step(we, wadr, wd, radr);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 14'd0, 32'd0, rand_radr());
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        step(1'b1, A(off), d, rand_radr());
    endtask

    task automatic rd(input int off);
        step(1'b0, 14'd0, 32'd0, A(off));
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    initial begin
        model_reset();
        #3;
        check("reset_led", 32'(led_out), 32'd0);
        check("reset_rdata_pass", dma_io_rdata, RD_IN);
        #20 rst_n = 1'b1;

        for (int i = 0; i < 4 + NCH + 1; i++) rd(i);

        wr(4, 32'd64);
        wr(1, 32'd0);
        wr(0, 32'd1);
        idle(300);
        hi_cnt = 0; cnt_on = 1;
        idle(256);
        cnt_on = 0;
        check("duty64_high_count", 32'(hi_cnt), 32'd64);

        wr(4, 32'd255); idle(300);
        wr(4, 32'd0);   idle(300);
        wr(4, 32'd64);  idle(300);
        idle(int'($urandom_range(20, 200)));
        wr(4, 32'd192); rd(4); idle(600);

        wr(2, 32'd1);
        wr(5, 32'h0001_0080);
        for (int i = 0; i < 1100; i++) if (i % 7 == 0) rd(3); else idle(1);

        wr(0, 32'd0);
        wr(6, 32'h0002_0000);
        idle(20);
        wr(0, 32'd1);
        idle(300);

        wr(1, 32'd3);
        idle(2200);
        idle(int'($urandom_range(1, 3)));
        wr(1, 32'd3);
        idle(50);

        wr(4 + NCH, $urandom());
        rd(4 + NCH);
        idle(5);

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #6;
        dma_io_we = 1'b0;
        dma_io_radr = A(0);
        rst_n = 1'b0;
        #1;
        check("async_reset_led", 32'(led_out), 32'd0);
        check("async_reset_rdata", dma_io_rdata, RD_IN);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4 + NCH; i++) rd(i);

        for (int n = 0; n < 15000; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                int off = int'($urandom_range(0, 4 + NCH));
                logic [31:0] d = $urandom();
                if (off == 1 || off == 2) d = 32'($urandom_range(0, 3));
                if (off == 0 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
                wr(off, d);
            end else if ($urandom_range(0, 199) == 0) begin
                step(1'b1, 14'h0042, $urandom(), rand_radr());
            end else begin
                idle(1);
            end
        end

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        #6;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
